// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration-bus arbiter.
//   msg_w()     : width of a config message {addr, flag, payload}
//   addr_lsb()  : bit position of the address field's LSB
//   flag_bit()  : bit position of the write/success flag
//   state_t     : arbiter FSM states
package cfg_pkg;

    localparam int unsigned ADDR_SIZE_DEF    = 4;
    localparam int unsigned PAYLOAD_SIZE_DEF = 8;

    function automatic int unsigned msg_w(int unsigned addr_size, int unsigned payload_size);
        return addr_size + payload_size + 1;
    endfunction

    function automatic int unsigned addr_lsb(int unsigned payload_size);
        return payload_size + 1;
    endfunction

    function automatic int unsigned flag_bit(int unsigned payload_size);
        return payload_size;
    endfunction

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        RETURN    = 2'd3
    } state_t;

endpackage

// File: rtl/config_rr_arbiter.sv
// Combinational round-robin picker.
//   req       : request vector
//   ptr       : highest-priority index for this decision
//   grant_oh  : one-hot winner (zero when nothing requests)
//   grant_idx : winner index (zero when nothing requests)
//   any       : at least one request present
module config_rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [PW-1:0]      grant_idx,
    output logic               any
);

    logic          any_hi;
    logic [PW-1:0] idx_hi;
    logic [PW-1:0] idx_lo;

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        any_hi = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (PW'(i) >= ptr)) begin
                any_hi = 1'b1;
                idx_hi = PW'(i);
            end
            if (req[i]) begin
                idx_lo = PW'(i);
            end
        end
        any       = |req;
        grant_idx = any_hi ? idx_hi : idx_lo;
        grant_oh  = any ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/config_bus_arbiter.sv
// Shares one config-register message channel between NUM_REQ requesters.
// Round-robin grant, one transaction in flight, response routed back to its
// originator; a watchdog converts a missing response into an error response.
//   clk, reset                  : clock, synchronous active-low reset
//   req_val/req_rdy/req_msg     : requester-side request channels
//   resp_val/resp_rdy/resp_msg  : requester-side response channels (shared msg)
//   cfg_req_*                   : request toward the config chain
//   cfg_resp_*                  : response from the config chain
//   busy                        : a transaction is in progress
//   timeout_err                 : one-cycle pulse, watchdog fired
//   stale_drop                  : one-cycle pulse, unsolicited response discarded
module config_bus_arbiter
    import cfg_pkg::*;
#(
    parameter  int unsigned ADDR_SIZE    = ADDR_SIZE_DEF,
    parameter  int unsigned PAYLOAD_SIZE = PAYLOAD_SIZE_DEF,
    parameter  int unsigned NUM_REQ      = 4,
    parameter  int unsigned TIMEOUT      = 16,
    localparam int unsigned MSG_W        = msg_w(ADDR_SIZE, PAYLOAD_SIZE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_val,
    output logic [NUM_REQ-1:0]       req_rdy,
    input  logic [NUM_REQ*MSG_W-1:0] req_msg,
    output logic [NUM_REQ-1:0]       resp_val,
    input  logic [NUM_REQ-1:0]       resp_rdy,
    output logic [MSG_W-1:0]         resp_msg,
    output logic                     cfg_req_val,
    input  logic                     cfg_req_rdy,
    output logic [MSG_W-1:0]         cfg_req_msg,
    input  logic                     cfg_resp_val,
    output logic                     cfg_resp_rdy,
    input  logic [MSG_W-1:0]         cfg_resp_msg,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     stale_drop
);

    localparam int unsigned PW       = $clog2(NUM_REQ);
    localparam int unsigned TW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TO_LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam int unsigned ADDR_LSB = addr_lsb(PAYLOAD_SIZE);

    state_t            state_q;
    state_t            state_nxt;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     grant_q;
    logic [TW-1:0]     timer_q;
    logic [MSG_W-1:0]  req_q;
    logic [MSG_W-1:0]  resp_q;
    logic              timeout_q;
    logic              stale_q;

    logic [NUM_REQ-1:0] win_oh;
    logic [PW-1:0]      win_idx;
    logic               win_any;
    logic [MSG_W-1:0]   req_sel;
    logic [MSG_W-1:0]   to_msg;
    logic [PW-1:0]      ptr_nxt;
    logic               timeout_hit;

    logic ld_req;
    logic ld_resp;
    logic ld_to;
    logic start_wait;
    logic done;
    logic stale_nxt;
    logic to_nxt;

    config_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (req_val),
        .ptr       (ptr_q),
        .grant_oh  (win_oh),
        .grant_idx (win_idx),
        .any       (win_any)
    );

    // Request payload of the current winner.
    always_comb begin
        req_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PW'(i)) begin
                req_sel = req_msg[i*MSG_W +: MSG_W];
            end
        end
    end

    // Error response: original address, success flag clear, zero payload.
    always_comb begin
        to_msg = '0;
        to_msg[ADDR_LSB +: ADDR_SIZE] = req_q[ADDR_LSB +: ADDR_SIZE];
    end

    assign ptr_nxt     = (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + PW'(1);
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TO_LAST));

    // Next state, register-load strobes and handshake outputs.
    // Control outputs are held low while reset is asserted.
    always_comb begin
        state_nxt    = state_q;
        ld_req       = 1'b0;
        ld_resp      = 1'b0;
        ld_to        = 1'b0;
        start_wait   = 1'b0;
        done         = 1'b0;
        stale_nxt    = 1'b0;
        to_nxt       = 1'b0;
        req_rdy      = '0;
        resp_val     = '0;
        cfg_req_val  = 1'b0;
        cfg_resp_rdy = 1'b0;

        case (state_q)
            IDLE: begin
                cfg_resp_rdy = 1'b1;
                stale_nxt    = cfg_resp_val;
                req_rdy      = win_oh;
                if (win_any) begin
                    ld_req    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cfg_req_val = 1'b1;
                if (cfg_req_rdy) begin
                    start_wait = 1'b1;
                    state_nxt  = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                cfg_resp_rdy = 1'b1;
                // A real response beats a watchdog expiry in the same cycle.
                if (cfg_resp_val) begin
                    ld_resp   = 1'b1;
                    state_nxt = RETURN;
                end else if (timeout_hit) begin
                    ld_to     = 1'b1;
                    to_nxt    = 1'b1;
                    state_nxt = RETURN;
                end
            end
            RETURN: begin
                resp_val = NUM_REQ'(1) << grant_q;
                if (resp_rdy[grant_q]) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (!reset) begin
            req_rdy      = '0;
            resp_val     = '0;
            cfg_req_val  = 1'b0;
            cfg_resp_rdy = 1'b0;
        end
    end

    // State, pointer, watchdog timer and holding registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            timer_q   <= '0;
            req_q     <= '0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            timeout_q <= to_nxt;
            stale_q   <= stale_nxt;
            if (ld_req) begin
                grant_q <= win_idx;
                req_q   <= req_sel;
            end
            // Saturating count of cycles spent waiting for a response.
            if (start_wait) begin
                timer_q <= '0;
            end else if ((state_q == WAIT_RESP) && (timer_q != '1)) begin
                timer_q <= timer_q + TW'(1);
            end
            if (ld_resp) begin
                resp_q <= cfg_resp_msg;
            end else if (ld_to) begin
                resp_q <= to_msg;
            end
            if (done) begin
                ptr_q <= ptr_nxt;
            end
        end
    end

    assign cfg_req_msg = req_q;
    assign resp_msg    = resp_q;
    assign busy        = reset && (state_q != IDLE);
    assign timeout_err = reset && timeout_q;
    assign stale_drop  = reset && stale_q;

endmodule

// File: tb/tb_config_bus_arbiter.sv
// Self-checking bench for config_bus_arbiter: transaction-level reference
// model compared every cycle, directed scenarios with literal expectations,
// then a randomized phase.
module tb_config_bus_arbiter;

    localparam int unsigned AS = 4;
    localparam int unsigned PS = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned MW = AS + PS + 1;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_val;
    logic [N-1:0]      req_rdy;
    logic [N*MW-1:0]   req_msg;
    logic [N-1:0]      resp_val;
    logic [N-1:0]      resp_rdy;
    logic [MW-1:0]     resp_msg;
    logic              cfg_req_val;
    logic              cfg_req_rdy;
    logic [MW-1:0]     cfg_req_msg;
    logic              cfg_resp_val;
    logic              cfg_resp_rdy;
    logic [MW-1:0]     cfg_resp_msg;
    logic              busy;
    logic              timeout_err;
    logic              stale_drop;

    config_bus_arbiter #(
        .ADDR_SIZE    (AS),
        .PAYLOAD_SIZE (PS),
        .NUM_REQ      (N),
        .TIMEOUT      (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_msg      (req_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_msg     (resp_msg),
        .cfg_req_val  (cfg_req_val),
        .cfg_req_rdy  (cfg_req_rdy),
        .cfg_req_msg  (cfg_req_msg),
        .cfg_resp_val (cfg_resp_val),
        .cfg_resp_rdy (cfg_resp_rdy),
        .cfg_resp_msg (cfg_resp_msg),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .stale_drop   (stale_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int grant_log[$];

    // Transaction-level model: one outstanding job and its progress flags.
    bit          m_act, m_iss, m_ans, m_stale, m_to;
    int          m_own, m_wait, m_ptr;
    logic [MW-1:0] m_req, m_resp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [MW-1:0] mk(input logic [AS-1:0] a, input logic f, input logic [PS-1:0] p);
        return {a, f, p};
    endfunction

    task automatic set_req(input int i, input logic [MW-1:0] m);
        req_msg[i*MW +: MW] = m;
    endtask

    task automatic model_check();
        logic [N-1:0] e_req_rdy, e_resp_val;
        logic e_cfg_req_val, e_cfg_resp_rdy, e_busy, e_to, e_stale;
        int w;
        e_req_rdy = '0;
        e_resp_val = '0;
        e_cfg_req_val = 0; e_cfg_resp_rdy = 0; e_busy = 0; e_to = 0; e_stale = 0;
        if (reset) begin
            if (!m_act) begin
                w = rr_pick(req_val, m_ptr);
                if (w >= 0) e_req_rdy[w] = 1'b1;
            end
            if (m_act && m_ans) e_resp_val[m_own] = 1'b1;
            e_cfg_req_val  = m_act && !m_iss;
            e_cfg_resp_rdy = !m_act || (m_iss && !m_ans);
            e_busy  = m_act;
            e_to    = m_to;
            e_stale = m_stale;
        end
        chk("req_rdy", 32'(req_rdy), 32'(e_req_rdy));
        chk("resp_val", 32'(resp_val), 32'(e_resp_val));
        chk("cfg_req_val", 32'(cfg_req_val), 32'(e_cfg_req_val));
        chk("cfg_resp_rdy", 32'(cfg_resp_rdy), 32'(e_cfg_resp_rdy));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("timeout_err", 32'(timeout_err), 32'(e_to));
        chk("stale_drop", 32'(stale_drop), 32'(e_stale));
        chk("resp_onehot", 32'($countones(resp_val) <= 1), 32'd1);
        if (e_cfg_req_val) chk("cfg_req_msg", 32'(cfg_req_msg), 32'(m_req));
        if (e_resp_val != '0) chk("resp_msg", 32'(resp_msg), 32'(m_resp));
    endtask

    task automatic model_update();
        int w;
        if (!reset) begin
            m_act = 0; m_iss = 0; m_ans = 0; m_stale = 0; m_to = 0;
            m_own = 0; m_wait = 0; m_ptr = 0;
            m_req = '0; m_resp = '0;
        end else begin
            m_stale = !m_act && cfg_resp_val;
            m_to = 0;
            if (!m_act) begin
                w = rr_pick(req_val, m_ptr);
                if (w >= 0) begin
                    m_act = 1; m_iss = 0; m_ans = 0; m_own = w;
                    m_req = req_msg[w*MW +: MW];
                end
            end else if (!m_iss) begin
                if (cfg_req_rdy) begin
                    m_iss = 1;
                    m_wait = 0;
                end
            end else if (!m_ans) begin
                if (cfg_resp_val) begin
                    m_ans = 1;
                    m_resp = cfg_resp_msg;
                end else if (TO != 0 && m_wait == int'(TO) - 1) begin
                    m_ans = 1;
                    m_resp = {m_req[MW-1 -: AS], {(PS+1){1'b0}}};
                    m_to = 1;
                end else begin
                    m_wait++;
                end
            end else if (resp_rdy[m_own]) begin
                m_act = 0;
                m_ptr = (m_own + 1) % N;
            end
        end
    endtask

    // One clock: compare against the model, then advance it on the edge.
    task automatic cyc();
        #1;
        if (reset && req_rdy != '0) begin
            for (int i = 0; i < N; i++) if (req_rdy[i]) grant_log.push_back(i);
        end
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_val = '0; resp_rdy = '0; cfg_req_rdy = 0; cfg_resp_val = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        idle_inputs();
        cyc();
        #1;
        chk("rst_cfg_resp_rdy", 32'(cfg_resp_rdy), 0);
        chk("rst_resp_msg", 32'(resp_msg), 0);
        chk("rst_busy", 32'(busy), 0);
        cyc();
        reset = 1;
    endtask

    initial begin
        reset = 0;
        req_msg = '0;
        cfg_resp_msg = '0;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // Single request from requester 2.
        req_val = 4'b0100;
        set_req(2, mk(4'h0, 1'b1, 8'hA5));
        #1 chk("t1_req_rdy", 32'(req_rdy), 32'h4);
        cyc();
        req_val = '0; cfg_req_rdy = 1;
        #1 chk("t1_cfg_req_val", 32'(cfg_req_val), 1);
        chk("t1_cfg_req_msg", 32'(cfg_req_msg), 32'h01A5);
        cyc();
        cfg_req_rdy = 0;
        cyc(); cyc();
        cfg_resp_val = 1; cfg_resp_msg = 13'h01A5;
        cyc();
        cfg_resp_val = 0; resp_rdy = 4'b0100;
        #1 chk("t1_resp_val", 32'(resp_val), 32'h4);
        chk("t1_resp_msg", 32'(resp_msg), 32'h01A5);
        cyc();
        resp_rdy = '0; req_val = '1;
        #1 chk("t1_ptr_next", 32'(req_rdy), 32'h8);
        req_val = '0;
        cyc();

        // All requesters valid: strict rotation from index 0.
        do_reset();
        grant_log.delete();
        req_val = '1; cfg_req_rdy = 1; cfg_resp_val = 1; resp_rdy = '1;
        cfg_resp_msg = 13'h1ABC;
        for (int c = 0; c < 60 && grant_log.size() < 8; c++) cyc();
        req_val = '0;
        for (int c = 0; c < 5; c++) cyc();
        chk("t2_grant_count", 32'(grant_log.size()), 8);
        for (int k = 0; k < grant_log.size() && k < 8; k++)
            chk("t2_grant_order", 32'(grant_log[k]), 32'(k % 4));

        // Backpressure on both sides plus watchdog expiry and late response.
        idle_inputs();
        req_val = 4'b0010;
        set_req(1, mk(4'h9, 1'b0, 8'h3C));
        cyc();
        req_val = '0;
        for (int c = 0; c < 5; c++) begin
            #1 chk("t3_issue_hold", 32'(cfg_req_msg), 32'h123C);
            chk("t3_issue_val", 32'(cfg_req_val), 1);
            cyc();
        end
        cfg_req_rdy = 1;
        cyc();
        cfg_req_rdy = 0;
        for (int k = 0; k < 16; k++) begin
            #1 chk("t4_no_early_to", 32'(timeout_err | (resp_val != 0)), 0);
            cyc();
        end
        #1 chk("t4_timeout_pulse", 32'(timeout_err), 1);
        chk("t4_resp_val", 32'(resp_val), 32'h2);
        for (int c = 0; c < 4; c++) begin
            #1 chk("t3_resp_hold", 32'(resp_msg), 32'h1200);
            cyc();
        end
        resp_rdy = 4'b0010;
        cyc();
        resp_rdy = '0; cfg_resp_val = 1; cfg_resp_msg = 13'h123C;
        cyc();
        cfg_resp_val = 0;
        #1 chk("t4_stale_pulse", 32'(stale_drop), 1);
        chk("t4_stale_no_resp", 32'(resp_val), 0);
        cyc();

        // Response on the exact watchdog cycle wins.
        req_val = 4'b0100;
        set_req(2, mk(4'h5, 1'b0, 8'h11));
        cyc();
        req_val = '0; cfg_req_rdy = 1;
        cyc();
        cfg_req_rdy = 0;
        for (int k = 0; k < 15; k++) cyc();
        cfg_resp_val = 1; cfg_resp_msg = 13'h0B7E;
        cyc();
        cfg_resp_val = 0; resp_rdy = 4'b0100;
        #1 chk("t5_no_timeout", 32'(timeout_err), 0);
        chk("t5_resp_val", 32'(resp_val), 32'h4);
        chk("t5_resp_msg", 32'(resp_msg), 32'h0B7E);
        cyc();
        resp_rdy = '0;

        // Reset pulse during WAIT_RESP, then normal service.
        req_val = 4'b1000;
        set_req(3, mk(4'h2, 1'b1, 8'h44));
        cyc();
        req_val = '0; cfg_req_rdy = 1;
        cyc();
        cfg_req_rdy = 0;
        cyc(); cyc();
        reset = 0; req_val = '1;
        #1 chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_req_rdy", 32'(req_rdy), 0);
        chk("t6_rst_cfg_resp_rdy", 32'(cfg_resp_rdy), 0);
        cyc();
        reset = 1;
        #1 chk("t6_ptr_zero", 32'(req_rdy), 32'h1);
        req_val = 4'b0001;
        set_req(0, mk(4'h7, 1'b1, 8'h99));
        cyc();
        req_val = '0; cfg_req_rdy = 1; cfg_resp_val = 1; cfg_resp_msg = 13'h0E55; resp_rdy = '1;
        cyc(); cyc();
        #1 chk("t6_served", 32'(resp_val), 32'h1);
        chk("t6_served_msg", 32'(resp_msg), 32'h0E55);
        cyc();
        idle_inputs();
        cyc();

        // Randomized traffic, alternating fast and slow config-chain responses.
        for (int c = 0; c < 4000; c++) begin
            reset        = ($urandom_range(199) != 0);
            req_val      = N'($urandom);
            req_msg      = (N*MW)'({$urandom(), $urandom()});
            cfg_req_rdy  = ($urandom_range(1) == 0);
            if (((c / 400) % 2) == 1) cfg_resp_val = ($urandom_range(39) == 0);
            else                     cfg_resp_val = ($urandom_range(2) == 0);
            cfg_resp_msg = MW'($urandom);
            resp_rdy     = N'($urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
